// File: rtl/axi4_pkg.sv
// Shared AXI4 channel widths and arbiter FSM encodings.
package axi4_pkg;
    localparam int ID_W    = 4;
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last completed winner.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_idx,
    output logic       gnt_idx
);
    logic last_q;

    // Reset to "m1 won last" so m0 takes the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)    last_q <= 1'b1;
        else if (done) last_q <= done_idx;
    end

    assign gnt_idx = (&req) ? ~last_q : req[1];
endmodule

// File: rtl/axi4_arbiter.sv
// Two-requester AXI4 arbiter onto one downstream port; read and write paths arbitrate independently.
module axi4_arbiter
    import axi4_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clock,
    input  logic                reset,
    // requester 0
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [LEN_W-1:0]    m0_arlen,
    input  logic [SIZE_W-1:0]   m0_arsize,
    input  logic [BURST_W-1:0]  m0_arburst,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [ID_W-1:0]     m0_rid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [RESP_W-1:0]   m0_rresp,
    output logic                m0_rlast,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [ID_W-1:0]     m0_awid,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [LEN_W-1:0]    m0_awlen,
    input  logic [SIZE_W-1:0]   m0_awsize,
    input  logic [BURST_W-1:0]  m0_awburst,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wlast,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    output logic [ID_W-1:0]     m0_bid,
    output logic [RESP_W-1:0]   m0_bresp,
    // requester 1
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [LEN_W-1:0]    m1_arlen,
    input  logic [SIZE_W-1:0]   m1_arsize,
    input  logic [BURST_W-1:0]  m1_arburst,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [ID_W-1:0]     m1_rid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [RESP_W-1:0]   m1_rresp,
    output logic                m1_rlast,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [LEN_W-1:0]    m1_awlen,
    input  logic [SIZE_W-1:0]   m1_awsize,
    input  logic [BURST_W-1:0]  m1_awburst,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ID_W-1:0]     m1_bid,
    output logic [RESP_W-1:0]   m1_bresp,
    // downstream
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ID_W-1:0]     s_arid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [LEN_W-1:0]    s_arlen,
    output logic [SIZE_W-1:0]   s_arsize,
    output logic [BURST_W-1:0]  s_arburst,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [ID_W-1:0]     s_rid,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [RESP_W-1:0]   s_rresp,
    input  logic                s_rlast,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ID_W-1:0]     s_awid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [LEN_W-1:0]    s_awlen,
    output logic [SIZE_W-1:0]   s_awsize,
    output logic [BURST_W-1:0]  s_awburst,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [ID_W-1:0]     s_bid,
    input  logic [RESP_W-1:0]   s_bresp
);
    rd_state_t r_state, r_next;
    wr_state_t w_state, w_next;
    logic      r_gnt_q, r_gnt_d, r_arb_gnt, r_done;
    logic      w_gnt_q, w_gnt_d, w_arb_gnt, w_done;
    logic      aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic      aw_hs, wl_hs;
    logic [1:0] ar_req, aw_req;

    assign ar_req = {m1_arvalid, m0_arvalid};
    assign aw_req = {m1_awvalid, m0_awvalid};

    rr_arb2 u_rd_arb (.clock(clock), .reset(reset), .req(ar_req), .done(r_done),
                      .done_idx(r_gnt_q), .gnt_idx(r_arb_gnt));
    rr_arb2 u_wr_arb (.clock(clock), .reset(reset), .req(aw_req), .done(w_done),
                      .done_idx(w_gnt_q), .gnt_idx(w_arb_gnt));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= R_IDLE;
            w_state   <= W_IDLE;
            r_gnt_q   <= 1'b0;
            w_gnt_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            r_state   <= r_next;
            w_state   <= w_next;
            r_gnt_q   <= r_gnt_d;
            w_gnt_q   <= w_gnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        r_next     = r_state;
        r_gnt_d    = r_gnt_q;
        r_done     = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: if (|ar_req) begin
                r_gnt_d = r_arb_gnt;
                r_next  = R_ADDR;
            end
            R_ADDR: begin
                s_arvalid  = ar_req[r_gnt_q];
                m0_arready = s_arready & ~r_gnt_q;
                m1_arready = s_arready &  r_gnt_q;
                if (s_arvalid && s_arready) r_next = R_DATA;
            end
            R_DATA: begin
                s_rready  = r_gnt_q ? m1_rready : m0_rready;
                m0_rvalid = s_rvalid & ~r_gnt_q;
                m1_rvalid = s_rvalid &  r_gnt_q;
                if (s_rvalid && s_rready && s_rlast) begin
                    r_next = R_IDLE;
                    r_done = 1'b1;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // AW and W are offered together; each side is masked once its handshake has landed.
    always_comb begin
        w_next     = w_state;
        w_gnt_d    = w_gnt_q;
        w_done     = 1'b0;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        aw_hs      = 1'b0;
        wl_hs      = 1'b0;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;
        m0_bvalid  = 1'b0;
        m1_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: if (|aw_req) begin
                w_gnt_d = w_arb_gnt;
                w_next  = W_ADDR;
            end
            W_ADDR: begin
                s_awvalid  = aw_req[w_gnt_q] & ~aw_done_q;
                s_wvalid   = (w_gnt_q ? m1_wvalid : m0_wvalid) & ~w_done_q;
                m0_awready = s_awready & ~aw_done_q & ~w_gnt_q;
                m1_awready = s_awready & ~aw_done_q &  w_gnt_q;
                m0_wready  = s_wready & ~w_done_q & ~w_gnt_q;
                m1_wready  = s_wready & ~w_done_q &  w_gnt_q;
                aw_hs      = s_awvalid & s_awready;
                wl_hs      = s_wvalid & s_wready & s_wlast;
                if (aw_hs) aw_done_d = 1'b1;
                if (wl_hs) w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    w_next    = W_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            W_RESP: begin
                s_bready  = w_gnt_q ? m1_bready : m0_bready;
                m0_bvalid = s_bvalid & ~w_gnt_q;
                m1_bvalid = s_bvalid &  w_gnt_q;
                if (s_bvalid && s_bready) begin
                    w_next = W_IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign s_arid    = r_gnt_q ? m1_arid    : m0_arid;
    assign s_araddr  = r_gnt_q ? m1_araddr  : m0_araddr;
    assign s_arlen   = r_gnt_q ? m1_arlen   : m0_arlen;
    assign s_arsize  = r_gnt_q ? m1_arsize  : m0_arsize;
    assign s_arburst = r_gnt_q ? m1_arburst : m0_arburst;
    assign s_awid    = w_gnt_q ? m1_awid    : m0_awid;
    assign s_awaddr  = w_gnt_q ? m1_awaddr  : m0_awaddr;
    assign s_awlen   = w_gnt_q ? m1_awlen   : m0_awlen;
    assign s_awsize  = w_gnt_q ? m1_awsize  : m0_awsize;
    assign s_awburst = w_gnt_q ? m1_awburst : m0_awburst;
    assign s_wdata   = w_gnt_q ? m1_wdata   : m0_wdata;
    assign s_wstrb   = w_gnt_q ? m1_wstrb   : m0_wstrb;
    assign s_wlast   = w_gnt_q ? m1_wlast   : m0_wlast;

    assign m0_rid   = s_rid;   assign m1_rid   = s_rid;
    assign m0_rdata = s_rdata; assign m1_rdata = s_rdata;
    assign m0_rresp = s_rresp; assign m1_rresp = s_rresp;
    assign m0_rlast = s_rlast; assign m1_rlast = s_rlast;
    assign m0_bid   = s_bid;   assign m1_bid   = s_bid;
    assign m0_bresp = s_bresp; assign m1_bresp = s_bresp;
endmodule

// File: tb/tb_axi4_arbiter.sv
// Scoreboard bench for axi4_arbiter: two scripted requesters, a simple memory model downstream.
module tb_axi4_arbiter;
    logic clock, reset;
    logic [1:0] arvalid, arready, rvalid, rready, rlast, awvalid, awready;
    logic [1:0] wvalid, wready, wlast, bvalid, bready;
    logic [1:0][3:0]  arid, rid, awid, bid;
    logic [1:0][31:0] araddr, awaddr;
    logic [1:0][7:0]  arlen, awlen, wstrb;
    logic [1:0][2:0]  arsize, awsize;
    logic [1:0][1:0]  arburst, awburst, rresp, bresp;
    logic [1:0][63:0] rdata, wdata;

    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, s_awvalid, s_awready;
    logic        s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [3:0]  s_arid, s_rid, s_awid, s_bid;
    logic [31:0] s_araddr, s_awaddr;
    logic [7:0]  s_arlen, s_awlen, s_wstrb;
    logic [2:0]  s_arsize, s_awsize;
    logic [1:0]  s_arburst, s_awburst, s_rresp, s_bresp;
    logic [63:0] s_rdata, s_wdata;

    int total = 0, bad = 0, r0_beats = 0, aw_delay = 0;
    logic [31:0] exp_ar[$], exp_aw[$];
    logic [64:0] exp_r0[$], exp_r1[$], exp_w[$];
    logic [5:0]  exp_b0[$], exp_b1[$];

    axi4_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(arvalid[0]), .m0_arready(arready[0]), .m0_arid(arid[0]), .m0_araddr(araddr[0]),
        .m0_arlen(arlen[0]), .m0_arsize(arsize[0]), .m0_arburst(arburst[0]),
        .m0_rvalid(rvalid[0]), .m0_rready(rready[0]), .m0_rid(rid[0]), .m0_rdata(rdata[0]),
        .m0_rresp(rresp[0]), .m0_rlast(rlast[0]),
        .m0_awvalid(awvalid[0]), .m0_awready(awready[0]), .m0_awid(awid[0]), .m0_awaddr(awaddr[0]),
        .m0_awlen(awlen[0]), .m0_awsize(awsize[0]), .m0_awburst(awburst[0]),
        .m0_wvalid(wvalid[0]), .m0_wready(wready[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]),
        .m0_wlast(wlast[0]), .m0_bvalid(bvalid[0]), .m0_bready(bready[0]), .m0_bid(bid[0]),
        .m0_bresp(bresp[0]),
        .m1_arvalid(arvalid[1]), .m1_arready(arready[1]), .m1_arid(arid[1]), .m1_araddr(araddr[1]),
        .m1_arlen(arlen[1]), .m1_arsize(arsize[1]), .m1_arburst(arburst[1]),
        .m1_rvalid(rvalid[1]), .m1_rready(rready[1]), .m1_rid(rid[1]), .m1_rdata(rdata[1]),
        .m1_rresp(rresp[1]), .m1_rlast(rlast[1]),
        .m1_awvalid(awvalid[1]), .m1_awready(awready[1]), .m1_awid(awid[1]), .m1_awaddr(awaddr[1]),
        .m1_awlen(awlen[1]), .m1_awsize(awsize[1]), .m1_awburst(awburst[1]),
        .m1_wvalid(wvalid[1]), .m1_wready(wready[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]),
        .m1_wlast(wlast[1]), .m1_bvalid(bvalid[1]), .m1_bready(bready[1]), .m1_bid(bid[1]),
        .m1_bresp(bresp[1]),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
        .s_bresp(s_bresp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [71:0] act);
        total++;
        bad++;
        $display("FAIL %s: unexpected transfer %h (nothing expected)", nm, act);
    endtask

    task automatic check_idle(input string nm);
        chk(nm, 72'({arready, rvalid, awready, wready, bvalid,
                     s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}), 72'd0);
    endtask

    function automatic int pending();
        return exp_ar.size() + exp_aw.size() + exp_r0.size() + exp_r1.size()
             + exp_w.size() + exp_b0.size() + exp_b1.size();
    endfunction

    task automatic wait_drain(input string nm);
        int n = 0;
        while (pending() > 0 && n < 500) begin
            @(posedge clock);
            n++;
        end
        chk({nm, "_drain"}, 72'(pending()), 72'd0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic m_read(input int m, input logic [31:0] a, input logic [3:0] id,
                          input logic [7:0] len);
        int  n = 0;
        logic hs = 1'b0;
        araddr[m] = a; arid[m] = id; arlen[m] = len; arvalid[m] = 1'b1;
        while (!hs && n < 300) begin
            @(negedge clock);
            hs = arready[m];
            n++;
        end
        if (!hs) unexpected("ar_timeout", 72'(m));
        @(posedge clock);
        #1;
        arvalid[m] = 1'b0;
    endtask

    task automatic m_write(input int m, input logic [31:0] a, input logic [3:0] id,
                           input logic [7:0] len, input logic [63:0] d0);
        int   n = 0;
        logic awp = 1'b1, wp = 1'b1, awh, wh;
        logic [7:0] beat = 8'd0;
        awaddr[m] = a; awid[m] = id; awlen[m] = len; awvalid[m] = 1'b1;
        wdata[m] = d0; wlast[m] = (len == 8'd0); wvalid[m] = 1'b1;
        while ((awp || wp) && n < 300) begin
            @(negedge clock);
            awh = awvalid[m] & awready[m];
            wh  = wvalid[m] & wready[m];
            n++;
            @(posedge clock);
            #1;
            if (awh) begin awvalid[m] = 1'b0; awp = 1'b0; end
            if (wh) begin
                if (wlast[m]) begin
                    wvalid[m] = 1'b0;
                    wp = 1'b0;
                end else begin
                    beat++;
                    wdata[m] = d0 + 64'(beat);
                    wlast[m] = (beat == len);
                end
            end
        end
        if (awp || wp) unexpected("aw_w_timeout", 72'(m));
    endtask

    // Read-side memory model: data = address + beat index, rid echoes arid.
    initial begin
        logic ar_hs, rl_hs, r_hs, arv, busy;
        logic [31:0] ra;
        logic [7:0]  rl, rc;
        logic [3:0]  ri;
        s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = '0; s_rid = '0; s_rresp = '0;
        busy = 0; ra = '0; rl = '0; rc = '0; ri = '0;
        forever begin
            @(negedge clock);
            ar_hs = s_arvalid & s_arready;
            r_hs  = s_rvalid & s_rready;
            rl_hs = r_hs & s_rlast;
            arv   = s_arvalid;
            if (ar_hs) begin ra = s_araddr; rl = s_arlen; ri = s_arid; end
            @(posedge clock);
            #1;
            if (!reset) begin
                s_arready = 0; s_rvalid = 0; s_rlast = 0; busy = 0;
            end else if (ar_hs) begin
                s_arready = 0; busy = 1; rc = 0;
                s_rvalid = 1; s_rid = ri; s_rdata = 64'(ra); s_rlast = (rl == 0);
            end else if (rl_hs) begin
                s_rvalid = 0; s_rlast = 0; busy = 0;
            end else if (r_hs) begin
                rc++;
                s_rdata = 64'(ra) + 64'(rc);
                s_rlast = (rc == rl);
            end else if (!busy) begin
                s_arready = arv;
            end
        end
    end

    // Write-side memory model: awready after aw_delay cycles, bresp = awid[1:0].
    initial begin
        logic awv, aw_hs, wl_hs, b_hs, awgot, wgot;
        logic [3:0] wi;
        int dly;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bid = '0; s_bresp = '0;
        awgot = 0; wgot = 0; dly = 0; wi = '0;
        forever begin
            @(negedge clock);
            awv   = s_awvalid;
            aw_hs = s_awvalid & s_awready;
            wl_hs = s_wvalid & s_wready & s_wlast;
            b_hs  = s_bvalid & s_bready;
            if (aw_hs) wi = s_awid;
            @(posedge clock);
            #1;
            if (!reset) begin
                s_awready = 0; s_wready = 0; s_bvalid = 0; awgot = 0; wgot = 0; dly = 0;
            end else begin
                s_wready = 1;
                if (b_hs) begin s_bvalid = 0; awgot = 0; wgot = 0; dly = 0; end
                if (aw_hs) begin
                    s_awready = 0; awgot = 1;
                end else if (awv && !awgot) begin
                    if (dly >= aw_delay) s_awready = 1;
                    else dly++;
                end
                if (wl_hs) wgot = 1;
                if (awgot && wgot && !s_bvalid && !b_hs) begin
                    s_bvalid = 1; s_bid = wi; s_bresp = wi[1:0];
                end
            end
        end
    end

    // Monitor: every handshake the DUT presents is matched against the scoreboard queues.
    initial begin
        logic [64:0] e;
        logic [5:0]  eb;
        forever begin
            @(negedge clock);
            if (s_arvalid && s_arready) begin
                if (exp_ar.size() == 0) unexpected("ar", 72'(s_araddr));
                else chk("ar_addr", 72'(s_araddr), 72'(exp_ar.pop_front()));
            end
            if (s_awvalid && s_awready) begin
                if (exp_aw.size() == 0) unexpected("aw", 72'(s_awaddr));
                else chk("aw_addr", 72'(s_awaddr), 72'(exp_aw.pop_front()));
            end
            if (s_wvalid && s_wready) begin
                if (exp_w.size() == 0) unexpected("w", 72'({s_wlast, s_wdata}));
                else chk("w_beat", 72'({s_wlast, s_wdata}), 72'(exp_w.pop_front()));
            end
            for (int m = 0; m < 2; m++) begin
                if (rvalid[m] && rready[m]) begin
                    if (m == 0) r0_beats++;
                    chk("r_other_quiet", 72'(rvalid[1-m]), 72'd0);
                    if ((m == 0 ? exp_r0.size() : exp_r1.size()) == 0) begin
                        unexpected(m == 0 ? "r_m0" : "r_m1", 72'({rlast[m], rdata[m]}));
                    end else begin
                        e = (m == 0) ? exp_r0.pop_front() : exp_r1.pop_front();
                        chk(m == 0 ? "r_m0_beat" : "r_m1_beat", 72'({rlast[m], rdata[m]}), 72'(e));
                    end
                end
                if (bvalid[m] && bready[m]) begin
                    chk("b_other_quiet", 72'(bvalid[1-m]), 72'd0);
                    if ((m == 0 ? exp_b0.size() : exp_b1.size()) == 0) begin
                        unexpected(m == 0 ? "b_m0" : "b_m1", 72'({bid[m], bresp[m]}));
                    end else begin
                        eb = (m == 0) ? exp_b0.pop_front() : exp_b1.pop_front();
                        chk(m == 0 ? "b_m0_resp" : "b_m1_resp", 72'({bid[m], bresp[m]}), 72'(eb));
                    end
                end
            end
        end
    end

    initial begin
        int n, base;
        reset = 0;
        arvalid = '0; awvalid = '0; wvalid = '0; wlast = '0;
        rready = '1; bready = '1;
        arid = '0; araddr = '0; arlen = '0; arsize = {3'd3, 3'd3}; arburst = {2'd1, 2'd1};
        awid = '0; awaddr = '0; awlen = '0; awsize = {3'd3, 3'd3}; awburst = {2'd1, 2'd1};
        wdata = '0; wstrb = '1;
        repeat (3) @(posedge clock);
        #1;
        check_idle("in_reset_idle");
        reset = 1;
        @(posedge clock);
        #1;
        check_idle("after_release_idle");

        // simultaneous reads: m0 first, m1 after m0's rlast
        exp_ar.push_back(32'h1000); exp_ar.push_back(32'h1100);
        exp_r0.push_back({1'b1, 64'h1000});
        exp_r1.push_back({1'b1, 64'h1100});
        fork
            m_read(0, 32'h1000, 4'h1, 8'd0);
            m_read(1, 32'h1100, 4'h9, 8'd0);
        join
        wait_drain("rr_tie");

        // m1 4-beat burst; m0 requests mid-burst and must wait
        exp_ar.push_back(32'h2000); exp_ar.push_back(32'h3000);
        exp_r1.push_back({1'b0, 64'h2000}); exp_r1.push_back({1'b0, 64'h2001});
        exp_r1.push_back({1'b0, 64'h2002}); exp_r1.push_back({1'b1, 64'h2003});
        exp_r0.push_back({1'b1, 64'h3000});
        fork
            m_read(1, 32'h2000, 4'h3, 8'd3);
            begin
                repeat (4) @(posedge clock);
                #1;
                m_read(0, 32'h3000, 4'h4, 8'd0);
            end
        join
        wait_drain("busy_wait");

        // m0 single-beat write with late awready
        aw_delay = 2;
        exp_aw.push_back(32'h8000);
        exp_w.push_back({1'b1, 64'hAAAA_0000_0000_0001});
        exp_b0.push_back({4'h2, 2'b10});
        m_write(0, 32'h8000, 4'h2, 8'd0, 64'hAAAA_0000_0000_0001);
        wait_drain("aw_late");
        aw_delay = 0;

        // m0 read concurrent with m1 two-beat write
        exp_ar.push_back(32'h4000);
        exp_r0.push_back({1'b1, 64'h4000});
        exp_aw.push_back(32'h5000);
        exp_w.push_back({1'b0, 64'h5555_0000_0000_0010});
        exp_w.push_back({1'b1, 64'h5555_0000_0000_0011});
        exp_b1.push_back({4'h5, 2'b01});
        fork
            m_read(0, 32'h4000, 4'h1, 8'd0);
            m_write(1, 32'h5000, 4'h5, 8'd1, 64'h5555_0000_0000_0010);
        join
        wait_drain("concurrent");

        // reset lands while beat 2 of 4 is on the bus
        base = r0_beats;
        exp_ar.push_back(32'h6000);
        exp_r0.push_back({1'b0, 64'h6000});
        m_read(0, 32'h6000, 4'h6, 8'd3);
        n = 0;
        while (r0_beats == base && n < 100) begin
            @(posedge clock);
            n++;
        end
        chk("beat1_seen", 72'(r0_beats - base), 72'd1);
        #2;
        reset = 0;
        #1;
        check_idle("reset_mid_burst");
        repeat (2) @(posedge clock);
        #1;
        check_idle("reset_held");
        reset = 1;
        @(posedge clock);
        #1;
        exp_ar.push_back(32'h7000);
        exp_r1.push_back({1'b0, 64'h7000});
        exp_r1.push_back({1'b1, 64'h7001});
        m_read(1, 32'h7000, 4'h3, 8'd1);
        wait_drain("post_reset_read");

        check_idle("final_idle");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
